// File: rtl/psg_arb_pkg.sv
// Shared types and helpers for the PSG bus arbitration tree.
package psg_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned HOLD_W  = 4;
    localparam int unsigned MAX_NCH = 32;
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    // One-hot vector with bit idx set; all-zero when idx is outside 0..n-1.
    function automatic logic [MAX_NCH-1:0] onehot(input int unsigned idx, input int unsigned n);
        if (idx < n) begin
            return MAX_NCH'(1) << idx;
        end
        return '0;
    endfunction

endpackage

// File: rtl/psg_prio_pick.sv
// Rotating priority encoder: first set bit of req searching upward from start, wrapping at NCH.
module psg_prio_pick
    import psg_arb_pkg::*;
#(
    parameter int unsigned NCH  = 8,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [SELW:0] cand;

    // Candidate index is formed one bit wider so start+k never overflows before the wrap.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = {1'b0, start} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(NCH)) begin
                cand = cand - (SELW+1)'(NCH);
            end
            if (!found && req[cand[SELW-1:0]]) begin
                idx   = cand[SELW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psg_bus_arb_rr.sv
// NCH-way bus arbiter with fixed-priority or round-robin selection and a bounded owner hold.
module psg_bus_arb_rr
    import psg_arb_pkg::*;
#(
    parameter int unsigned NCH      = 8,
    parameter int unsigned SELW     = $clog2(NCH),
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              ack,
    input  logic              mode,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    sel,
    output logic [SELW-1:0]   seln,
    output logic              gnt_vld,
    output logic [HOLD_W-1:0] hold_cnt
);

    logic [SELW-1:0] lp;
    logic [SELW:0]   lp_inc;
    logic [SELW-1:0] start;
    logic [SELW-1:0] pick_idx;
    logic            pick_found;
    logic            keep;
    logic            slot;
    logic [SELW-1:0] win;
    arb_mode_e       mode_e;

    assign mode_e = arb_mode_e'(mode);

    // Search start: index 0 in fixed mode, one past the last owner (mod NCH) in round robin.
    always_comb begin
        lp_inc = {1'b0, lp} + (SELW+1)'(1);
        if (lp_inc >= (SELW+1)'(NCH)) begin
            lp_inc = '0;
        end
        start = (mode_e == ARB_RR) ? lp_inc[SELW-1:0] : '0;
    end

    psg_prio_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_pick (
        .req   (req),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A sole requester is re-granted by the rotating search itself, since lp tracks the owner.
    always_comb begin
        keep = (mode_e == ARB_RR) && gnt_vld && req[seln] && (hold_cnt < HOLD_W'(MAX_HOLD));
        win  = keep ? seln : pick_idx;
        slot = ce && ack && pick_found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= '0;
            seln     <= '0;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
            lp       <= SELW'(NCH - 1);
        end else if (slot) begin
            sel     <= NCH'(onehot(32'(win), NCH));
            seln    <= win;
            gnt_vld <= 1'b1;
            lp      <= win;
            if (gnt_vld && (win == seln)) begin
                hold_cnt <= (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= HOLD_W'(1);
            end
        end
    end

endmodule
